// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core and its display stage:
// status codes, core state/command encodings and seven-segment glyphs.
package calc_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = 4;

   typedef enum logic [1:0] {
      STATUS_ERRO    = 2'b00,
      STATUS_OCUPADO = 2'b01,
      STATUS_PRONTO  = 2'b10
   } status_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_OPERANDO_A = 3'd1,
      ST_OPERACAO   = 3'd2,
      ST_OPERANDO_B = 3'd3,
      ST_RESULTADO  = 3'd4,
      ST_ERRO       = 3'd5
   } calc_state_t;

   typedef enum logic [3:0] {
      CMD_SOMA      = 4'b1010,
      CMD_SUB       = 4'b1011,
      CMD_MULT      = 4'b1100,
      CMD_IGUAL     = 4'b1110,
      CMD_BACKSPACE = 4'b1111
   } cmd_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

   // Error frame glyph per digit position: "Erro" on digits 3..0
   function automatic logic [6:0] err_glyph(input logic [2:0] digit);
      case (digit)
         3'd0:       err_glyph = SEG_O;
         3'd1, 3'd2: err_glyph = SEG_R;
         3'd3:       err_glyph = SEG_E;
         default:    err_glyph = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/calc_display_driver_if.sv
// Digit/status stream from the calculator core and the display pins.
interface calc_display_driver_if;
   logic [3:0] data;
   logic [3:0] pos;
   logic [1:0] status;
   logic [7:0] an;
   logic [6:0] seg;

   modport master (output data, pos, status, input an, seg);
   modport slave  (input data, pos, status, output an, seg);
endinterface

// File: rtl/calc_display_driver_seg7_decoder.sv
// BCD code to active-low seven-segment pattern; codes 10-15 render blank.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display_driver.sv
// Shadow/visible digit buffers with commit on entry to pronto, error
// override, leading-zero blanking and a one-hot multiplexed anode scan.
module calc_display_driver
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   calc_display_driver_if.slave  bus
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_nxt;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] visible;
   logic [NUM_DIGITS-1:0][6:0]         dec_seg;
   logic [NUM_DIGITS-1:0][6:0]         frame;
   logic [NUM_DIGITS-1:0]              lz;
   logic                               zero_above;
   logic [1:0]                         prev_status;
   logic [DIV_W-1:0]                   div;
   logic [2:0]                         idx;
   logic                               commit;
   logic                               err;

   assign commit = (bus.status == STATUS_PRONTO) && (prev_status != STATUS_PRONTO);
   assign err    = (bus.status == STATUS_ERRO);

   // Same-cycle capture is folded in so a commit sees the newest digit
   always_comb begin
      shadow_nxt = shadow;
      if (!bus.pos[3])
         shadow_nxt[bus.pos[2:0]] = bus.data;
   end

   // Codes 10-15 are non-zero here, so they stop the blanking run
   always_comb begin
      zero_above = 1'b1;
      lz         = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above && (visible[i] == 4'd0);
         lz[i]      = zero_above && LZ_BLANK;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seg7_decoder u_dec (
         .code (visible[g]),
         .seg  (dec_seg[g])
      );
      assign frame[g] = err   ? err_glyph(3'(g)) :
                        lz[g] ? SEG_BLANK        : dec_seg[g];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shadow      <= '0;
         visible     <= '0;
         prev_status <= STATUS_OCUPADO;
         div         <= '0;
         idx         <= '0;
         bus.an      <= 8'hFF;
         bus.seg     <= SEG_BLANK;
      end else begin
         shadow      <= shadow_nxt;
         prev_status <= bus.status;
         if (commit)
            visible <= shadow_nxt;
         if (div == DIV_W'(REFRESH_DIV - 1)) begin
            div <= '0;
            idx <= idx + 3'd1;
         end else begin
            div <= div + 1'b1;
         end
         bus.an  <= ~(8'b1 << idx);
         bus.seg <= frame[idx];
      end
   end

endmodule

// File: tb/tb_calc_display_driver.sv
// Scoreboard bench: a digit-buffer model predicts each scan slot.
module tb_calc_display_driver;

   localparam int RD = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] data;
   logic [3:0] pos;
   logic [1:0] status;

   always #5 clock = ~clock;

   calc_display_driver_if ifa ();
   calc_display_driver_if ifb ();

   assign ifa.data   = data;
   assign ifa.pos    = pos;
   assign ifa.status = status;
   assign ifb.data   = data;
   assign ifb.pos    = pos;
   assign ifb.status = status;

   calc_display_driver #(.REFRESH_DIV(RD), .LZ_BLANK(1'b1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (ifa)
   );

   calc_display_driver #(.REFRESH_DIV(RD), .LZ_BLANK(1'b0)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (ifb)
   );

   int          checks = 0;
   int          errors = 0;
   logic [14:0] sb[$];
   logic [3:0]  m_shadow[8];
   logic [3:0]  m_vis[8];
   logic [1:0]  m_prev;

   function automatic logic [6:0] digit_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int i, input bit lzb, input bit err);
      bit hi_zero;
      if (err) begin
         case (i)
            0:       return 7'h23;
            1, 2:    return 7'h2F;
            3:       return 7'h06;
            default: return 7'h7F;
         endcase
      end
      if (lzb && i > 0) begin
         hi_zero = 1'b1;
         for (int j = i; j < 8; j++)
            if (m_vis[j] != 4'd0) hi_zero = 1'b0;
         if (hi_zero) return 7'h7F;
      end
      return digit_seg(m_vis[i]);
   endfunction

   function automatic logic [14:0] observe(input bit on_b);
      return on_b ? {ifb.an, ifb.seg} : {ifa.an, ifa.seg};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = 4'd0;
         m_vis[i]    = 4'd0;
      end
      m_prev = 2'b01;
   endtask

   // One cycle of stimulus; the model advances as of the coming posedge
   task automatic drive(input logic [3:0] d, input logic [3:0] p, input logic [1:0] s);
      @(negedge clock);
      data   = d;
      pos    = p;
      status = s;
      if (!p[3]) m_shadow[p[2:0]] = d;
      if (s == 2'b10 && m_prev != 2'b10)
         for (int i = 0; i < 8; i++) m_vis[i] = m_shadow[i];
      m_prev = s;
   endtask

   task automatic idle(input int n, input logic [1:0] s);
      for (int k = 0; k < n; k++) drive(4'd0, 4'd8, s);
   endtask

   task automatic check_frame(input string name, input bit on_b, input bit err);
      logic [7:0]  prev_an;
      logic [14:0] e, got;
      bit          found;
      for (int i = 0; i < 8; i++)
         sb.push_back({~(8'b1 << i), exp_seg(i, !on_b, err)});
      found   = 1'b0;
      got     = observe(on_b);
      prev_an = got[14:7];
      for (int t = 0; t < 20 * RD && !found; t++) begin
         @(negedge clock);
         got = observe(on_b);
         if (got[14:7] == 8'hFE && prev_an != 8'hFE) found = 1'b1;
         prev_an = got[14:7];
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: scan never reached an=FE (an=%h)", name, prev_an);
         sb.delete();
         return;
      end
      @(negedge clock);
      for (int k = 0; k < 8; k++) begin
         e   = sb.pop_front();
         got = observe(on_b);
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s slot %0d: got an=%h seg=%h, want an=%h seg=%h",
                     name, k, got[14:7], got[6:0], e[14:7], e[6:0]);
         end
         if (k < 7) repeat (RD) @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      data   = 4'd0;
      pos    = 4'd8;
      status = 2'b01;
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (ifa.an !== 8'hFF) begin
         errors++;
         $display("FAIL reset_an: got %h want FF", ifa.an);
      end
      checks++;
      if (ifa.seg !== 7'h7F) begin
         errors++;
         $display("FAIL reset_seg: got %h want 7F", ifa.seg);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ifa.an, ifa.seg} !== {8'hFE, 7'h40}) begin
         errors++;
         $display("FAIL first_scan: got an=%h seg=%h want an=FE seg=40", ifa.an, ifa.seg);
      end
      check_frame("reset_frame", 1'b0, 1'b0);
   endtask

   task automatic test_commit();
      logic [3:0] dig[8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      for (int p = 0; p < 8; p++) drive(dig[p], 4'(p), 2'b01);
      drive(4'd0, 4'd8, 2'b10);
      idle(2, 2'b10);
      check_frame("commit_123", 1'b0, 1'b0);
   endtask

   task automatic test_hold_pronto();
      drive(4'd9, 4'd0, 2'b10);
      drive(4'd9, 4'd1, 2'b10);
      for (int p = 2; p < 8; p++) drive(4'd0, 4'(p), 2'b10);
      idle(2, 2'b10);
      check_frame("hold_no_recommit", 1'b0, 1'b0);
      drive(4'd0, 4'd8, 2'b01);
      drive(4'd0, 4'd8, 2'b10);
      idle(2, 2'b10);
      check_frame("recommit_99", 1'b0, 1'b0);
   endtask

   task automatic test_error();
      drive(4'd4, 4'd0, 2'b00);
      idle(2, 2'b00);
      check_frame("error_frame", 1'b0, 1'b1);
      idle(2, 2'b01);
      check_frame("error_exit_no_commit", 1'b0, 1'b0);
      drive(4'd0, 4'd8, 2'b10);
      idle(2, 2'b10);
      check_frame("capture_during_error", 1'b0, 1'b0);
   endtask

   task automatic test_ignored_pos();
      for (int p = 8; p < 16; p++) drive(4'd7, 4'(p), 2'b01);
      drive(4'd0, 4'd8, 2'b10);
      idle(2, 2'b10);
      check_frame("pos_8_15_ignored", 1'b0, 1'b0);
      for (int p = 1; p < 8; p++) drive(4'd0, 4'(p), 2'b01);
      drive(4'd5, 4'd0, 2'b10);
      idle(2, 2'b10);
      check_frame("capture_in_commit", 1'b0, 1'b0);
   endtask

   task automatic test_lz_off();
      check_frame("lz_off_5", 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_scan();
      bit found = 1'b0;
      for (int t = 0; t < 20 * RD && !found; t++) begin
         @(negedge clock);
         if (ifa.an == 8'hDF) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset_wait: an=DF never seen (an=%h)", ifa.an);
      end
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      checks++;
      if ({ifa.an, ifa.seg} !== {8'hFF, 7'h7F}) begin
         errors++;
         $display("FAIL mid_reset: got an=%h seg=%h want an=FF seg=7F", ifa.an, ifa.seg);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ifa.an, ifa.seg} !== {8'hFE, 7'h40}) begin
         errors++;
         $display("FAIL mid_reset_restart: got an=%h seg=%h want an=FE seg=40", ifa.an, ifa.seg);
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_hold_pronto();
      test_error();
      test_ignored_pos();
      test_lz_off();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
